// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: request handshake plus read-response return.
// The master modport is the requester, the slave modport is the arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [NUM_WMASKS-1:0] wmask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, wmask, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, wmask, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port OpenRAM-style SRAM (port 0).
// Optional grant statistics counters are compiled in with SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_arbiter_if.slave    r0,
  sram_port_arbiter_if.slave    r1,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic [15:0]           gnt_cnt0,
  output logic [15:0]           gnt_cnt1
);

  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [NUM_WMASKS-1:0] req_wmask [2];
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  assign req_valid    = {r1.valid, r0.valid};
  assign req_we       = {r1.we, r0.we};
  assign req_wmask[0] = r0.wmask;
  assign req_wmask[1] = r1.wmask;
  assign req_addr[0]  = r0.addr;
  assign req_addr[1]  = r1.addr;
  assign req_wdata[0] = r0.wdata;
  assign req_wdata[1] = r1.wdata;

  // last_gnt_reg = 1 means requester 1 won most recently, so requester 0 wins the first tie
  logic                  last_gnt_reg;
  logic                  gnt_id;
  logic                  accept;
  logic [1:0]            ready_vec;
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    accept = |req_valid;
    gnt_id = req_valid[1];
    if (&req_valid) begin
      gnt_id = ~last_gnt_reg;
    end
    sel_we    = req_we[gnt_id];
    sel_wmask = req_wmask[gnt_id];
    sel_addr  = req_addr[gnt_id];
    sel_wdata = req_wdata[gnt_id];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n & req_valid[gi] & (gnt_id == 1'(gi));
    end
  endgenerate

  assign r0.ready = ready_vec[0];
  assign r1.ready = ready_vec[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_reg <= 1'b1;
      sram_csb0    <= 1'b1;
      sram_web0    <= 1'b1;
      sram_wmask0  <= '0;
      sram_addr0   <= '0;
      sram_din0    <= '0;
    end else if (accept) begin
      last_gnt_reg <= gnt_id;
      sram_csb0    <= 1'b0;
      sram_web0    <= ~sel_we;
      sram_wmask0  <= sel_we ? sel_wmask : '0;
      sram_addr0   <= sel_addr;
      sram_din0    <= sel_wdata;
    end else begin
      sram_csb0    <= 1'b1;
      sram_web0    <= 1'b1;
      sram_wmask0  <= '0;
    end
  end

  // Stage 0 = read issued to SRAM pins, stage 1 = SRAM sampling; dout is captured one edge later
  logic [1:0] pipe_vld_reg;
  logic [1:0] pipe_id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_reg <= '0;
      pipe_id_reg  <= '0;
    end else begin
      pipe_vld_reg <= {pipe_vld_reg[0], accept & ~sel_we};
      pipe_id_reg  <= {pipe_id_reg[0], gnt_id};
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic                  rvalid_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  rsp_hit;

      assign rsp_hit = pipe_vld_reg[1] & (pipe_id_reg[1] == 1'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= rsp_hit;
          if (rsp_hit) begin
            rdata_reg <= sram_dout0;
          end
        end
      end
    end
  endgenerate

  assign r0.rvalid = g_rsp[0].rvalid_reg;
  assign r0.rdata  = g_rsp[0].rdata_reg;
  assign r1.rvalid = g_rsp[1].rvalid_reg;
  assign r1.rdata  = g_rsp[1].rdata_reg;

`ifdef SRAM_ARB_STATS_EN
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (accept && (gnt_id == 1'(gi)) && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign gnt_cnt0 = g_cnt[0].cnt_reg;
  assign gnt_cnt1 = g_cnt[1].cnt_reg;
`else
  assign gnt_cnt0 = 16'd0;
  assign gnt_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM and a request-level reference model.
module tb_sram_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) r0_if ();
  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) r1_if ();

  logic          sram_csb0, sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;
  logic [15:0]   gnt_cnt0, gnt_cnt1;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .r0(r0_if), .r1(r1_if),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // Behavioural SRAM: samples at rising edge, reads return after that edge, writes land on the falling edge
  logic [DW-1:0] sram_mem [512];
  logic          wr_pend = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NW-1:0] wr_mask;
  always @(posedge clk) begin
    wr_pend <= !sram_csb0 && !sram_web0;
    wr_addr <= sram_addr0;
    wr_data <= sram_din0;
    wr_mask <= sram_wmask0;
    if (!sram_csb0 && sram_web0) sram_dout0 <= sram_mem[sram_addr0];
  end
  always @(negedge clk) begin
    if (wr_pend)
      for (int b = 0; b < NW; b++)
        if (wr_mask[b]) sram_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  typedef struct { int id; logic [DW-1:0] data; int due; } rsp_t;
  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [512];
  logic          m_last;
  int            m_cnt [2];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] exp_rdata [2];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_addr = '0;
    m_din = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_q.delete();
  endtask

  task automatic set_port(input int k, input logic v, input logic we, input logic [NW-1:0] wm,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (k == 0) begin
      r0_if.valid = v; r0_if.we = we; r0_if.wmask = wm; r0_if.addr = a; r0_if.wdata = d;
    end else begin
      r1_if.valid = v; r1_if.we = we; r1_if.wmask = wm; r1_if.addr = a; r1_if.wdata = d;
    end
  endtask

  // One clock of traffic: inputs were set at the falling edge; predict grant, then check the SRAM pins
  task automatic step();
    logic v0, v1, g, acc, we;
    logic [NW-1:0] wm;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0] exp_rdy;
    logic [63:0] exp_bus;
    logic [31:0] exp_cnt;
    #1;
    v0 = r0_if.valid;
    v1 = r1_if.valid;
    acc = v0 | v1;
    if (v0 && v1) g = (m_last == 1'b1) ? 1'b0 : 1'b1;
    else g = v1;
    exp_rdy = !acc ? 2'b00 : (g ? 2'b10 : 2'b01);
    chk("ready", {62'd0, r1_if.ready, r0_if.ready}, {62'd0, exp_rdy});
    we = g ? r1_if.we : r0_if.we;
    wm = g ? r1_if.wmask : r0_if.wmask;
    a  = g ? r1_if.addr : r0_if.addr;
    d  = g ? r1_if.wdata : r0_if.wdata;
    @(posedge clk);
    #1;
    if (acc) begin
      m_last = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
      m_addr = a;
      m_din = d;
      if (we) begin
        for (int b = 0; b < NW; b++)
          if (wm[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_q.push_back('{id: int'(g), data: ref_mem[a], due: cyc + 2});
      end
      exp_bus = {17'd0, 1'b0, ~we, (we ? wm : 4'h0), a, d};
    end else begin
      exp_bus = {17'd0, 1'b1, 1'b1, 4'h0, m_addr, m_din};
    end
    chk("sram_bus", {17'd0, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0}, exp_bus);
`ifdef SRAM_ARB_STATS_EN
    exp_cnt = {16'(m_cnt[1]), 16'(m_cnt[0])};
`else
    exp_cnt = 32'd0;
`endif
    chk("gnt_cnt", {32'd0, gnt_cnt1, gnt_cnt0}, {32'd0, exp_cnt});
    @(negedge clk);
  endtask

  // Monitor: every cycle compare response outputs against the head of the expected queue
  always begin
    logic [1:0] exp_v;
    @(posedge clk);
    #1;
    exp_v = 2'b00;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_v[exp_q[0].id] = 1'b1;
      exp_rdata[exp_q[0].id] = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("rvalid", {62'd0, r1_if.rvalid, r0_if.rvalid}, {62'd0, exp_v});
    chk("rdata0", {32'd0, r0_if.rdata}, {32'd0, exp_rdata[0]});
    chk("rdata1", {32'd0, r1_if.rdata}, {32'd0, exp_rdata[1]});
  end

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i] = v;
    end
    sram_mem[9'h010] = 32'hDEADBEEF;
    ref_mem[9'h010]  = 32'hDEADBEEF;
    sram_mem[9'h1FF] = 32'hAAAAAAAA;
    ref_mem[9'h1FF]  = 32'hAAAAAAAA;
    model_reset();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0, '0);

    // Reset state, and ready held low while in reset even with requests pending
    repeat (3) @(negedge clk);
    set_port(0, 1'b1, 1'b0, '0, 9'h005, '0);
    set_port(1, 1'b1, 1'b1, 4'hF, 9'h006, 32'h1);
    #1;
    chk("ready_in_reset", {62'd0, r1_if.ready, r0_if.ready}, 64'd0);
    chk("reset_bus", {17'd0, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
        {17'd0, 1'b1, 1'b1, 4'h0, 9'h000, 32'h0});
    chk("reset_cnt", {32'd0, gnt_cnt1, gnt_cnt0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b1, 1'b0, '0, 9'(9'h020 + i), '0);
      set_port(1, 1'b1, 1'b0, '0, 9'(9'h030 + i), '0);
      step();
    end
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Single read of the preloaded word
    set_port(0, 1'b1, 1'b0, '0, 9'h010, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Byte-masked write followed immediately by a read of the same word
    set_port(1, 1'b1, 1'b1, 4'b0101, 9'h1FF, 32'h11223344);
    step();
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    set_port(0, 1'b1, 1'b0, '0, 9'h1FF, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Back-to-back reads from alternating requesters
    set_port(0, 1'b1, 1'b0, '0, 9'h001, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b1, 1'b0, '0, 9'h002, '0);
    step();
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    set_port(0, 1'b1, 1'b0, '0, 9'h003, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) step();

    // Reset while a read is in flight: response dropped, pins idle at once, r0 wins next tie
    set_port(1, 1'b1, 1'b0, '0, 9'h004, '0);
    step();
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    set_port(0, 1'b1, 1'b0, '0, 9'h007, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("csb_async_reset", {63'd0, sram_csb0}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, '0, 9'h008, '0);
    set_port(1, 1'b1, 1'b0, '0, 9'h009, '0);
    step();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Random mixed traffic over a small address window to force read-after-write hits
    for (int i = 0; i < 3000; i++) begin
      set_port(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               9'($urandom_range(0, 15)), $urandom);
      set_port(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               9'($urandom_range(0, 15)), $urandom);
      step();
    end

    // Long single-requester run drives gnt_cnt0 into saturation when statistics are built in
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 70000; i++) begin
      set_port(0, 1'b1, 1'b0, '0, 9'($urandom), '0);
      step();
    end
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 9, SRAM word address width; DATA_WIDTH, default 32, SRAM data width; NUM_WMASKS, default 4, byte-lane write-enable count.
REQ-002 SHALL have ports: clk input 1, single clock shared with SRAM clk0; rst_n input 1, reset, asynchronous active-low.
REQ-003 SHALL have, per requester k in {0,1}: rk_valid input 1, request valid; rk_ready output 1, request accepted this cycle; rk_we input 1, 1=write 0=read; rk_wmask input NUM_WMASKS, byte enables; rk_addr input ADDR_WIDTH, word address; rk_wdata input DATA_WIDTH, write data; rk_rvalid output 1, read data valid; rk_rdata output DATA_WIDTH, read data.
REQ-004 SHALL have SRAM port-0 outputs: sram_csb0 1, sram_web0 1, sram_wmask0 NUM_WMASKS, sram_addr0 ADDR_WIDTH, sram_din0 DATA_WIDTH; SRAM input sram_dout0 DATA_WIDTH.
REQ-005 SHALL have outputs gnt_cnt0 and gnt_cnt1, 16 bits each, grant statistics (see Configuration).

Function
REQ-006 Arbitration SHALL be combinational each cycle: exactly one of r0_ready/r1_ready high when any rk_valid is high; both low when neither valid.
REQ-007 Only one valid -> that requester granted.
REQ-008 Both valid -> grant the requester not granted most recently (round-robin); last-grant pointer updates only on an accepted request.
REQ-009 Transfer occurs at the rising edge where rk_valid and rk_ready are both high; rk_ready SHALL NOT depend on rk_we/addr/data.
REQ-010 Accepted request SHALL be registered into sram_* outputs at that edge: csb0=0, web0=~we, addr0, din0=wdata, wmask0=wmask for writes and all-zero for reads.
REQ-011 Cycle with no accept SHALL register sram_csb0=1, sram_web0=1, sram_wmask0=0; addr0/din0 hold.
REQ-012 Throughput SHALL be one accepted request per cycle, back-to-back, any read/write mix, any requester sequence.
REQ-013 Read accepted at edge E: SRAM samples at E+1, data valid at E+2; arbiter SHALL assert rk_rvalid for exactly one cycle after edge E+2 with rk_rdata = sram_dout0 registered at E+2, k = original requester.
REQ-014 A 2-stage shift register of {valid, requester id} SHALL track in-flight reads; up to 2 reads outstanding.
REQ-015 rk_rdata SHALL hold its last value when rk_rvalid is low; no response backpressure (requesters always accept).
REQ-016 Writes SHALL produce no response; a write is complete from the arbiter's view at acceptance.
REQ-017 Read issued the cycle after a write to the same address SHALL return the new data (SRAM writes on the falling edge before the read samples); no forwarding logic.
REQ-018 Responses SHALL return in acceptance order; r0_rvalid and r1_rvalid never high together.

Reset
REQ-019 rst_n low SHALL asynchronously force: sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, r0/r1_rvalid=0, r0/r1_rdata=0, pipeline valids=0, last-grant pointer=1 (requester 0 wins first tie), gnt_cnt0/1=0.
REQ-020 Reset with reads in flight SHALL discard them; no rvalid after release for pre-reset requests.
REQ-021 rk_ready SHALL be 0 while rst_n is low.

Configuration
REQ-022 Macro SRAM_ARB_STATS_EN defined: gnt_cntk SHALL increment by 1 on each accept by requester k, saturating at 16'hFFFF.
REQ-023 Macro SRAM_ARB_STATS_EN undefined: no counter flops; gnt_cnt0/1 tied to 0; all other behaviour identical.

Verification
REQ-024 Single read: preload mem[0x010]=0xDEADBEEF; r0 read 0x010 accepted at edge 5 -> r0_rvalid high one cycle after edge 7, r0_rdata=0xDEADBEEF; r1_rvalid stays 0.
REQ-025 Contention: r0 and r1 both valid for 4 cycles from reset -> grants 0,1,0,1; sram_addr0 follows the same order, one per cycle.
REQ-026 Byte write: r1 write addr 0x1FF, wdata 0x11223344, wmask 4'b0101 over mem 0xAAAAAAAA, then r0 read 0x1FF next cycle -> r0_rdata=0xAA22AA44.
REQ-027 Back-to-back reads r0@0x001, r1@0x002, r0@0x003 on consecutive edges -> rvalid on three consecutive cycles, correct requester and data, order preserved.
REQ-028 Reset mid-flight: r0 read accepted, rst_n low 1 cycle later -> no r0_rvalid, sram_csb0=1 immediately, next tie grants r0.
REQ-029 With SRAM_ARB_STATS_EN: 70000 r0 accepts -> gnt_cnt0=16'hFFFF; without macro both counters read 0.
